// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the shared MIPS datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      instr;
  logic             eq;
  logic             imem_ready;
  logic             dmem_ready;
  logic             PCWr;
  logic             IRWr;
  logic             WeGrf;
  logic             WeDm;
  logic [1:0]       RegDst;
  logic [1:0]       WhichtoReg;
  logic             AluSrc;
  logic [2:0]       AluOp;
  logic             sign;
  logic             branch;
  logic             JType;
  logic             JReg;
  logic [2:0]       state;
  logic             retire;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, eq, imem_ready, dmem_ready,
    output PCWr, IRWr, WeGrf, WeDm, RegDst, WhichtoReg, AluSrc, AluOp,
           sign, branch, JType, JReg, state, retire, retired
  );

  modport slave (
    output instr, eq, imem_ready, dmem_ready,
    input  PCWr, IRWr, WeGrf, WeDm, RegDst, WhichtoReg, AluSrc, AluOp,
           sign, branch, JType, JReg, state, retire, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/GRF/DM strobes per state and counts retired instructions.
//   state | meaning
//   IF    | wait for imem_ready, latch IR and advance PC by 4
//   ID    | decode; jumps and nops finish here
//   EXE   | ALU operation; beq resolves and finishes here
//   MEM   | DM access for lw/sw, held until dmem_ready
//   WB    | GRF write-back
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic [5:0]       op, funct;
  logic             is_rtype, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
  logic             is_beq, is_lui, is_j, is_jal, is_exe_op;
  logic             alu_src, sign_ext;
  logic [2:0]       alu_op;
  logic             unused_instr_bits;

  assign op       = bus.instr[31:26];
  assign funct    = bus.instr[5:0];
  assign is_rtype = (op == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_lui   = (op == 6'b001111);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  assign is_exe_op = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_lui;
  assign unused_instr_bits = ^bus.instr[25:6];

  // ALU controls are a pure function of the held IR, so EXE, MEM and WB present identical values.
  assign alu_src  = is_ori | is_lui | is_lw | is_sw;
  assign sign_ext = is_lw | is_sw | is_beq;
  assign alu_op   = (is_subu | is_beq) ? 3'd1 :
                    is_ori             ? 3'd2 :
                    is_lui             ? 3'd3 : 3'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.retire) retired_q <= retired_q + 1'b1;
    end
  end

  // Everything is gated by reset so that an async reset drops every strobe in the same instant.
  always_comb begin
    state_d        = state_q;
    bus.PCWr       = 1'b0;
    bus.IRWr       = 1'b0;
    bus.WeGrf      = 1'b0;
    bus.WeDm       = 1'b0;
    bus.RegDst     = 2'd0;
    bus.WhichtoReg = 2'd0;
    bus.AluSrc     = 1'b0;
    bus.AluOp      = 3'd0;
    bus.sign       = 1'b0;
    bus.branch     = 1'b0;
    bus.JType      = 1'b0;
    bus.JReg       = 1'b0;
    bus.retire     = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          if (bus.imem_ready) begin
            bus.PCWr = 1'b1;
            bus.IRWr = 1'b1;
            state_d  = S_ID;
          end
        end
        S_ID: begin
          if (is_j) begin
            bus.PCWr   = 1'b1;
            bus.JType  = 1'b1;
            bus.retire = 1'b1;
            state_d    = S_IF;
          end else if (is_jr) begin
            bus.PCWr   = 1'b1;
            bus.JReg   = 1'b1;
            bus.retire = 1'b1;
            state_d    = S_IF;
          end else if (is_jal) begin
            bus.PCWr       = 1'b1;
            bus.JType      = 1'b1;
            bus.WeGrf      = 1'b1;
            bus.RegDst     = 2'd2;
            bus.WhichtoReg = 2'd2;
            bus.retire     = 1'b1;
            state_d        = S_IF;
          end else if (is_exe_op) begin
            state_d = S_EXE;
          end else begin
            bus.retire = 1'b1;
            state_d    = S_IF;
          end
        end
        S_EXE: begin
          bus.AluSrc = alu_src;
          bus.AluOp  = alu_op;
          bus.sign   = sign_ext;
          if (is_beq) begin
            bus.branch = 1'b1;
            bus.PCWr   = bus.eq;
            bus.retire = 1'b1;
            state_d    = S_IF;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          bus.AluSrc = alu_src;
          bus.AluOp  = alu_op;
          bus.sign   = sign_ext;
          bus.WeDm   = is_sw;
          if (bus.dmem_ready) begin
            if (is_sw) begin
              bus.retire = 1'b1;
              state_d    = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          bus.AluSrc     = alu_src;
          bus.AluOp      = alu_op;
          bus.sign       = sign_ext;
          bus.WeGrf      = 1'b1;
          bus.RegDst     = is_rtype ? 2'd1 : 2'd0;
          bus.WhichtoReg = is_lw ? 2'd1 : 2'd0;
          bus.retire     = 1'b1;
          state_d        = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl with a narrow-counter twin for wrap checking.
module tb_multicycle_ctrl;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        eq;
    logic        im;
    logic        dm;
    logic [2:0]  st;
    logic [16:0] ctl;
  } vec_t;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SUBU = 32'h00221823;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_UNK  = 32'hFC000000;
  localparam logic [31:0] I_ORI  = 32'h34220055;
  localparam logic [31:0] I_LUI  = 32'h3C021234;
  localparam logic [31:0] I_J    = 32'h08000004;
  localparam logic [31:0] I_JR   = 32'h03E00008;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_cnt;
  vec_t tbl[$];

  multicycle_ctrl_if #(.CNT_W(32)) mbus ();
  multicycle_ctrl_if #(.CNT_W(3))  nbus ();

  multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(mbus));
  multicycle_ctrl #(.CNT_W(3))  dut2 (.clk(clk), .reset(reset), .bus(nbus));

  assign nbus.instr      = mbus.instr;
  assign nbus.eq         = mbus.eq;
  assign nbus.imem_ready = mbus.imem_ready;
  assign nbus.dmem_ready = mbus.dmem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWr,IRWr,WeGrf,WeDm,RegDst,WhichtoReg,AluSrc,AluOp,sign,branch,JType,JReg,retire}
  function automatic logic [16:0] mk(int pc, int ir, int wg, int wd, int rd, int wr, int as,
                                     int ao, int sg, int br, int jt, int jr, int rt);
    logic [16:0] r;
    r = {pc[0], ir[0], wg[0], wd[0], rd[1:0], wr[1:0], as[0], ao[2:0], sg[0], br[0], jt[0],
         jr[0], rt[0]};
    return r;
  endfunction

  function automatic logic [16:0] act_ctl();
    return {mbus.PCWr, mbus.IRWr, mbus.WeGrf, mbus.WeDm, mbus.RegDst, mbus.WhichtoReg,
            mbus.AluSrc, mbus.AluOp, mbus.sign, mbus.branch, mbus.JType, mbus.JReg,
            mbus.retire};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] i, input int e, input int im,
                     input int dm, input int s, input logic [16:0] c);
    vec_t v;
    v.name = n; v.instr = i; v.eq = e[0]; v.im = im[0]; v.dm = dm[0]; v.st = s[2:0]; v.ctl = c;
    tbl.push_back(v);
  endtask

  // Called just after a falling edge; leaves time at the next falling edge.
  task automatic step(input string n, input logic [31:0] i, input logic e, input logic im,
                      input logic dm, input logic [2:0] s, input logic [16:0] c);
    mbus.instr = i; mbus.eq = e; mbus.imem_ready = im; mbus.dmem_ready = dm;
    #1;
    chk({n, ".state"}, {29'd0, mbus.state}, {29'd0, s});
    chk({n, ".ctl"}, {15'd0, act_ctl()}, {15'd0, c});
    chk({n, ".retired"}, mbus.retired, exp_cnt);
    if (c[0]) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] fetch, exe_mem, wdm;
    checks = 0; failures = 0; exp_cnt = 0;
    fetch   = mk(1,1,0,0,0,0,0,0,0,0,0,0,0);
    exe_mem = mk(0,0,0,0,0,0,1,0,1,0,0,0,0);
    wdm     = mk(0,0,0,1,0,0,1,0,1,0,0,0,0);

    add("addu_if",  I_ADDU, 0,1,1, 0, fetch);
    add("addu_id",  I_ADDU, 0,1,1, 1, 17'd0);
    add("addu_exe", I_ADDU, 0,1,1, 2, 17'd0);
    add("addu_wb",  I_ADDU, 0,1,1, 4, mk(0,0,1,0,1,0,0,0,0,0,0,0,1));
    add("lw_if",    I_LW,   0,1,1, 0, fetch);
    add("lw_id",    I_LW,   0,1,1, 1, 17'd0);
    add("lw_exe",   I_LW,   0,1,0, 2, exe_mem);
    for (int k = 0; k < 4; k++) add("lw_mem_wait", I_LW, 0,1,0, 3, exe_mem);
    add("lw_mem_done", I_LW, 0,1,1, 3, exe_mem);
    add("lw_wb",    I_LW,   0,1,1, 4, mk(0,0,1,0,0,1,1,0,1,0,0,0,1));
    add("sw_if",    I_SW,   0,1,1, 0, fetch);
    add("sw_id",    I_SW,   0,1,1, 1, 17'd0);
    add("sw_exe",   I_SW,   0,1,0, 2, exe_mem);
    for (int k = 0; k < 4; k++) add("sw_mem_wait", I_SW, 0,1,0, 3, wdm);
    add("sw_mem_done", I_SW, 0,1,1, 3, mk(0,0,0,1,0,0,1,0,1,0,0,0,1));
    add("beq1_if",  I_BEQ,  1,1,1, 0, fetch);
    add("beq1_id",  I_BEQ,  1,1,1, 1, 17'd0);
    add("beq1_exe", I_BEQ,  1,1,1, 2, mk(1,0,0,0,0,0,0,1,1,1,0,0,1));
    add("beq0_if",  I_BEQ,  0,1,1, 0, fetch);
    add("beq0_id",  I_BEQ,  0,1,1, 1, 17'd0);
    add("beq0_exe", I_BEQ,  0,1,1, 2, mk(0,0,0,0,0,0,0,1,1,1,0,0,1));
    add("jal_if",   I_JAL,  0,1,1, 0, fetch);
    add("jal_id",   I_JAL,  0,1,1, 1, mk(1,0,1,0,2,2,0,0,0,0,1,0,1));
    add("unk_if",   I_UNK,  0,1,1, 0, fetch);
    add("unk_id",   I_UNK,  0,1,1, 1, mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    add("ori_if_wait", I_ORI, 0,0,1, 0, 17'd0);
    add("ori_if_wait", I_ORI, 0,0,1, 0, 17'd0);
    add("ori_if",   I_ORI,  0,1,1, 0, fetch);
    add("ori_id",   I_ORI,  0,1,1, 1, 17'd0);
    add("ori_exe",  I_ORI,  0,1,1, 2, mk(0,0,0,0,0,0,1,2,0,0,0,0,0));
    add("ori_wb",   I_ORI,  0,1,1, 4, mk(0,0,1,0,0,0,1,2,0,0,0,0,1));
    add("lui_if",   I_LUI,  0,1,1, 0, fetch);
    add("lui_id",   I_LUI,  0,1,1, 1, 17'd0);
    add("lui_exe",  I_LUI,  0,1,1, 2, mk(0,0,0,0,0,0,1,3,0,0,0,0,0));
    add("lui_wb",   I_LUI,  0,1,1, 4, mk(0,0,1,0,0,0,1,3,0,0,0,0,1));
    add("subu_if",  I_SUBU, 0,1,1, 0, fetch);
    add("subu_id",  I_SUBU, 0,1,1, 1, 17'd0);
    add("subu_exe", I_SUBU, 0,1,1, 2, mk(0,0,0,0,0,0,0,1,0,0,0,0,0));
    add("subu_wb",  I_SUBU, 0,1,1, 4, mk(0,0,1,0,1,0,0,1,0,0,0,0,1));
    add("j_if",     I_J,    0,1,1, 0, fetch);
    add("j_id",     I_J,    0,1,1, 1, mk(1,0,0,0,0,0,0,0,0,0,1,0,1));
    add("jr_if",    I_JR,   0,1,1, 0, fetch);
    add("jr_id",    I_JR,   0,1,1, 1, mk(1,0,0,0,0,0,0,0,0,0,0,1,1));

    // Reset held for 3 cycles with imem_ready high: nothing may strobe.
    reset = 1'b0;
    mbus.instr = I_ADDU; mbus.eq = 1'b0; mbus.imem_ready = 1'b1; mbus.dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rst.state", {29'd0, mbus.state}, 32'd0);
      chk("rst.ctl", {15'd0, act_ctl()}, 32'd0);
      chk("rst.retired", mbus.retired, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].name, tbl[k].instr, tbl[k].eq, tbl[k].im, tbl[k].dm, tbl[k].st, tbl[k].ctl);

    chk("wrap.retired3", {29'd0, nbus.retired}, exp_cnt % 8);

    // Reset pulled in the middle of a stalled sw.
    step("sw2_if",  I_SW, 1'b0, 1'b1, 1'b1, 3'd0, fetch);
    step("sw2_id",  I_SW, 1'b0, 1'b1, 1'b1, 3'd1, 17'd0);
    step("sw2_exe", I_SW, 1'b0, 1'b1, 1'b0, 3'd2, exe_mem);
    #1;
    chk("sw2_mem.WeDm", {31'd0, mbus.WeDm}, 32'd1);
    chk("sw2_mem.state", {29'd0, mbus.state}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst.WeDm", {31'd0, mbus.WeDm}, 32'd0);
    chk("midrst.state", {29'd0, mbus.state}, 32'd0);
    chk("midrst.ctl", {15'd0, act_ctl()}, 32'd0);
    chk("midrst.retired", mbus.retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step("post_if", I_ADDU, 1'b0, 1'b1, 1'b1, 3'd0, fetch);
    step("post_id", I_ADDU, 1'b0, 1'b1, 1'b1, 3'd1, 17'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
